vga_layer_mixer: RTL

- Parametrised pixel compositor between the sprite/background generators and the TinyVGA PMOD output mapping.
- Selects one of NUM_BG background sources, using either a manual select or an automatic frame-timed cycle.
- Overlays NUM_LAYERS sprite layers in fixed priority, forces black during blanking, and delays hsync/vsync so they stay aligned with the colour pipeline.
- Background select and layer enables change only at frame boundaries, so no change lands mid-frame.

---
 rtl/vga_layer_mixer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vga_layer_mixer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vga_layer_mixer
// Brief    : Pixel compositor. Picks a background (manual or frame-timed
//            auto-cycle), overlays prioritised sprite layers, blanks outside
//            the visible area and delays syncs to match the 2-cycle colour
//            pipeline. Background select and layer enables only change at
//            frame boundaries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vga_layer_mixer #(
  parameter int NUM_LAYERS    = 2,
  parameter int NUM_BG        = 4,
  parameter int FRAMES_PER_BG = 60,
  parameter int SYNC_POL      = 0,
  localparam int SELW         = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    video_active,
  input  logic [NUM_LAYERS-1:0]   layer_hit,
  input  logic [6*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic [6*NUM_BG-1:0]     bg_rgb,
  input  logic [SELW-1:0]         bg_sel,
  input  logic                    auto_mode,
  output logic [1:0]              R,
  output logic [1:0]              G,
  output logic [1:0]              B,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [SELW-1:0]         active_bg
);

  localparam logic        SYNC_ACT   = (SYNC_POL != 0);
  localparam logic        SYNC_INACT = ~SYNC_ACT;
  localparam logic [15:0] LAST_FRAME = 16'(FRAMES_PER_BG - 1);
  localparam logic [SELW-1:0] LAST_BG = SELW'(NUM_BG - 1);

  // Frame-boundary state
  logic [SELW-1:0]       r_active_bg;
  logic [15:0]           r_frame_cnt;
  logic [NUM_LAYERS-1:0] r_en_shadow;

  // Sync delay lines; r_vs[0] doubles as the registered vsync for edge detect
  logic [1:0] r_hs;
  logic [1:0] r_vs;

  // Pipeline stage 1 / stage 2
  logic [5:0] r_s1_layer;
  logic       r_s1_hit;
  logic [5:0] r_s1_bg;
  logic       r_s1_active;
  logic [5:0] r_rgb;

  // Combinational helpers
  logic            w_frame_start;
  logic [5:0]      w_layer_rgb;
  logic            w_layer_hit;
  logic [5:0]      w_bg_rgb;
  logic [SELW-1:0] w_next_bg;

  assign w_frame_start = (vsync_in == SYNC_ACT) && (r_vs[0] == SYNC_INACT);
  assign w_next_bg     = (r_active_bg == LAST_BG) ? '0 : r_active_bg + 1'b1;

  // Priority pick: scan high-to-low so the lowest enabled hitting layer wins
  always_comb begin
    w_layer_rgb = '0;
    w_layer_hit = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i] && r_en_shadow[i]) begin
        w_layer_rgb = layer_rgb[6*i +: 6];
        w_layer_hit = 1'b1;
      end
    end
  end

  // Background mux; an out-of-range index matches nothing and yields black
  always_comb begin
    w_bg_rgb = '0;
    for (int j = 0; j < NUM_BG; j++) begin
      if (r_active_bg == SELW'(j)) begin
        w_bg_rgb = bg_rgb[6*j +: 6];
      end
    end
  end

  // Background selection, auto-cycle counter and enable shadow, frame-gated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_bg <= '0;
      r_frame_cnt <= '0;
      r_en_shadow <= '1;
    end else if (w_frame_start) begin
      r_en_shadow <= layer_en;
      if (!auto_mode) begin
        r_active_bg <= bg_sel;
        r_frame_cnt <= '0;
      end else if (r_frame_cnt == LAST_FRAME) begin
        r_frame_cnt <= '0;
        r_active_bg <= w_next_bg;
      end else begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Two-stage colour pipeline; stage 1 sees active_bg before any same-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_layer  <= '0;
      r_s1_hit    <= 1'b0;
      r_s1_bg     <= '0;
      r_s1_active <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_s1_layer  <= w_layer_rgb;
      r_s1_hit    <= w_layer_hit;
      r_s1_bg     <= w_bg_rgb;
      r_s1_active <= video_active;
      if (!r_s1_active) begin
        r_rgb <= '0;
      end else if (r_s1_hit) begin
        r_rgb <= r_s1_layer;
      end else begin
        r_rgb <= r_s1_bg;
      end
    end
  end

  // Sync delay matching the colour pipeline depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs <= {2{SYNC_INACT}};
      r_vs <= {2{SYNC_INACT}};
    end else begin
      r_hs <= {r_hs[0], hsync_in};
      r_vs <= {r_vs[0], vsync_in};
    end
  end

  assign R         = r_rgb[5:4];
  assign G         = r_rgb[3:2];
  assign B         = r_rgb[1:0];
  assign hsync_out = r_hs[1];
  assign vsync_out = r_vs[1];
  assign active_bg = r_active_bg;

endmodule
`default_nettype wire
